// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg: RV32M funct3 encodings, FSM state codes and op-class helpers.
// Rev 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam logic [2:0] c_op_mul    = 3'd0;
  localparam logic [2:0] c_op_mulh   = 3'd1;
  localparam logic [2:0] c_op_mulhsu = 3'd2;
  localparam logic [2:0] c_op_mulhu  = 3'd3;
  localparam logic [2:0] c_op_div    = 3'd4;
  localparam logic [2:0] c_op_divu   = 3'd5;
  localparam logic [2:0] c_op_rem    = 3'd6;
  localparam logic [2:0] c_op_remu   = 3'd7;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_calc = 2'd1;
  localparam logic [1:0] c_st_fix  = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  function automatic logic op_is_div(input logic [2:0] f);
    return (f == c_op_div) || (f == c_op_divu) || (f == c_op_rem) || (f == c_op_remu);
  endfunction

  function automatic logic op_is_rem(input logic [2:0] f);
    return (f == c_op_rem) || (f == c_op_remu);
  endfunction

  function automatic logic op_is_mul_high(input logic [2:0] f);
    return (f == c_op_mulh) || (f == c_op_mulhsu) || (f == c_op_mulhu);
  endfunction

  // MUL is treated as unsigned: the low half of the product is sign-agnostic.
  function automatic logic op_is_signed_a(input logic [2:0] f);
    return (f == c_op_mulh) || (f == c_op_mulhsu) || (f == c_op_div) || (f == c_op_rem);
  endfunction

  function automatic logic op_is_signed_b(input logic [2:0] f);
    return (f == c_op_mulh) || (f == c_op_div) || (f == c_op_rem);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_if.sv
// ============================================================================
// muldiv_if: request/result bundle between pipeline control and muldiv_unit.
// Rev 1.0
// ============================================================================
`default_nettype none

interface muldiv_if #(
  parameter int N = 32
);
  logic         start;
  logic         flush;
  logic [2:0]   funct3;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [4:0]   rd_in;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic [4:0]   rd_out;
  logic         wb_en;

  modport master (
    output start, flush, funct3, op_a, op_b, rd_in,
    input  busy, done, result, rd_out, wb_en
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b, rd_in,
    output busy, done, result, rd_out, wb_en
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ============================================================================
// muldiv_iter: shared radix-2 shift-add / restoring-divide datapath + counter.
// Optional single-cycle product via MULDIV_FAST_MUL_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_iter #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           is_div,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic [CW-1:0]  count,
  output logic [N-1:0]   acc,
  output logic [N-1:0]   quo,
  output logic [2*N-1:0] prod
);

  logic [N-1:0] r_dvs;
  logic [N:0]   w_sum;
  logic [N:0]   w_shift;
  logic         w_ge;
  logic [N-1:0] w_sub;

  always_comb begin
    w_sum   = {1'b0, acc} + {1'b0, r_dvs};
    w_shift = {acc, quo[N-1]};
    w_ge    = (w_shift >= {1'b0, r_dvs});
    w_sub   = w_shift[N-1:0] - r_dvs;
`ifdef MULDIV_FAST_MUL_EN
    prod    = {{N{1'b0}}, quo} * {{N{1'b0}}, r_dvs};
`else
    prod    = {acc, quo};
`endif
  end

  // {acc,quo} is the product register for multiply and {remainder,quotient} for divide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      acc   <= '0;
      quo   <= '0;
      r_dvs <= '0;
    end else if (load) begin
      count <= CW'(N);
      acc   <= '0;
      quo   <= a_in;
      r_dvs <= b_in;
    end else if (step) begin
      count <= count - 1'b1;
      if (is_div) begin
        if (w_ge) begin
          acc <= w_sub;
          quo <= {quo[N-2:0], 1'b1};
        end else begin
          acc <= w_shift[N-1:0];
          quo <= {quo[N-2:0], 1'b0};
        end
      end else if (quo[0]) begin
        acc <= w_sum[N:1];
        quo <= {w_sum[0], quo[N-1:1]};
      end else begin
        acc <= {1'b0, acc[N-1:1]};
        quo <= {acc[0], quo[N-1:1]};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit: iterative RV32M multiply/divide unit (FSM, sign fix, outputs).
// MULDIV_FAST_MUL_EN sends multiplies straight to FIX.   Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  logic [1:0]     r_state;
  logic [1:0]     w_next;
  logic [2:0]     r_funct3;
  logic           r_neg_q;
  logic           r_neg_r;
  logic           r_divz;
  logic [N-1:0]   r_result;
  logic [4:0]     r_rd;

  logic           w_accept;
  logic           w_sign_a;
  logic           w_sign_b;
  logic           w_divz;
  logic [N-1:0]   w_a_mag;
  logic [N-1:0]   w_b_mag;

  logic [CW-1:0]  w_count;
  logic [N-1:0]   w_acc;
  logic [N-1:0]   w_quo;
  logic [2*N-1:0] w_prod;
  logic [2*N-1:0] w_prod_s;
  logic [N-1:0]   w_quo_s;
  logic [N-1:0]   w_rem_mag;
  logic [N-1:0]   w_rem_s;
  logic [N-1:0]   w_fix;

  always_comb begin
    w_accept = (r_state == c_st_idle) && bus.start && !bus.flush;
    w_sign_a = op_is_signed_a(bus.funct3) && bus.op_a[N-1];
    w_sign_b = op_is_signed_b(bus.funct3) && bus.op_b[N-1];
    w_a_mag  = w_sign_a ? (~bus.op_a + 1'b1) : bus.op_a;
    w_b_mag  = w_sign_b ? (~bus.op_b + 1'b1) : bus.op_b;
    w_divz   = op_is_div(bus.funct3) && (bus.op_b == '0);
  end

  muldiv_iter #(.N(N), .CW(CW)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (w_accept),
    .step   (r_state == c_st_calc),
    .is_div (op_is_div(r_funct3)),
    .a_in   (w_a_mag),
    .b_in   (w_b_mag),
    .count  (w_count),
    .acc    (w_acc),
    .quo    (w_quo),
    .prod   (w_prod)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_accept) begin
`ifdef MULDIV_FAST_MUL_EN
          w_next = (w_divz || !op_is_div(bus.funct3)) ? c_st_fix : c_st_calc;
`else
          w_next = w_divz ? c_st_fix : c_st_calc;
`endif
        end
      end
      c_st_calc: begin
        if (bus.flush)
          w_next = c_st_idle;
        else if (w_count == CW'(1))
          w_next = c_st_fix;
      end
      c_st_fix:  w_next = bus.flush ? c_st_idle : c_st_done;
      default:   w_next = c_st_idle;
    endcase
  end

  // On divide-by-zero the datapath never steps, so quo still holds |op_a|;
  // re-applying the dividend sign yields op_a unmodified as the remainder.
  always_comb begin
    w_prod_s  = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    w_quo_s   = r_divz ? '1 : (r_neg_q ? (~w_quo + 1'b1) : w_quo);
    w_rem_mag = r_divz ? w_quo : w_acc;
    w_rem_s   = r_neg_r ? (~w_rem_mag + 1'b1) : w_rem_mag;
    if (op_is_div(r_funct3))
      w_fix = op_is_rem(r_funct3) ? w_rem_s : w_quo_s;
    else if (op_is_mul_high(r_funct3))
      w_fix = w_prod_s[2*N-1:N];
    else
      w_fix = w_prod_s[N-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= c_st_idle;
      r_funct3 <= c_op_mul;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_divz   <= 1'b0;
      r_result <= '0;
      r_rd     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_funct3 <= bus.funct3;
        r_neg_q  <= w_sign_a ^ w_sign_b;
        r_neg_r  <= w_sign_a;
        r_divz   <= w_divz;
        r_rd     <= bus.rd_in;
      end
      if ((r_state == c_st_fix) && !bus.flush)
        r_result <= w_fix;
    end
  end

  assign bus.busy   = (r_state != c_st_idle);
  assign bus.done   = (r_state == c_st_done);
  assign bus.result = r_result;
  assign bus.rd_out = r_rd;
  assign bus.wb_en  = bus.done && (r_rd != 5'd0);

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  muldiv_if #(.N(32)) bus ();

  muldiv_unit #(.N(32), .CW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output int lat,
                        output logic wb);
    @(negedge clk);
    bus.funct3 = f; bus.op_a = a; bus.op_b = b; bus.rd_in = rd; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    wb  = bus.wb_en;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en: got %b want 0", bus.wb_en); end
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
    n_checks++; if (bus.rd_out !== 5'd0) begin n_fail++; $display("FAIL reset_rd_out: got %0d want 0", bus.rd_out); end
  endtask

  task automatic test_mul();
    logic [31:0] res; int lat; logic wb;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, res, lat, wb);
    n_checks++; if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result: got %h want ffffffeb", res); end
    n_checks++; if (lat != MUL_LAT) begin n_fail++; $display("FAIL mul_latency: got %0d want %0d", lat, MUL_LAT); end
    n_checks++; if (wb !== 1'b1) begin n_fail++; $display("FAIL mul_wb_en: got %b want 1", wb); end
    n_checks++; if (bus.rd_out !== 5'd5) begin n_fail++; $display("FAIL mul_rd_out: got %0d want 5", bus.rd_out); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mul_done_width: got %b want 0", bus.done); end
  endtask

  task automatic test_mulh();
    logic [31:0] res; int lat; logic wb;
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, res, lat, wb);
    n_checks++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_result: got %h want fffffffe", res); end
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, res, lat, wb);
    n_checks++; if (res !== 32'h0000_0000) begin n_fail++; $display("FAIL mulh_result: got %h want 00000000", res); end
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, res, lat, wb);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu_result: got %h want ffffffff", res); end
    n_checks++; if (lat != MUL_LAT) begin n_fail++; $display("FAIL mulhsu_latency: got %0d want %0d", lat, MUL_LAT); end
  endtask

  task automatic test_div();
    logic [31:0] res; int lat; logic wb;
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, res, lat, wb);
    n_checks++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_result: got %h want fffffffd", res); end
    n_checks++; if (lat != 34) begin n_fail++; $display("FAIL div_latency: got %0d want 34", lat); end
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, res, lat, wb);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_result: got %h want ffffffff", res); end
    run_op(3'd5, 32'd5, 32'd0, 5'd6, res, lat, wb);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_by0_result: got %h want ffffffff", res); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL divu_by0_latency: got %0d want 2", lat); end
    run_op(3'd7, 32'd5, 32'd0, 5'd6, res, lat, wb);
    n_checks++; if (res !== 32'd5) begin n_fail++; $display("FAIL remu_by0_result: got %h want 00000005", res); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL remu_by0_latency: got %0d want 2", lat); end
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd6, res, lat, wb);
    n_checks++; if (res !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL rem_by0_signed: got %h want fffffff9", res); end
  endtask

  task automatic test_overflow();
    logic [31:0] res; int lat; logic wb;
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, res, lat, wb);
    n_checks++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_div_result: got %h want 80000000", res); end
    n_checks++; if (lat != 34) begin n_fail++; $display("FAIL ovf_done_seen: latency %0d want 34", lat); end
    n_checks++; if (wb !== 1'b0) begin n_fail++; $display("FAIL ovf_wb_en_rd0: got %b want 0", wb); end
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, res, lat, wb);
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL ovf_rem_result: got %h want 00000000", res); end
  endtask

  task automatic test_flush();
    logic [31:0] res; int lat; logic wb; int pulses;
    run_op(3'd5, 32'd100, 32'd7, 5'd3, res, lat, wb);
    n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL divu_100_7: got %h want 0000000e", res); end
    @(negedge clk);
    bus.funct3 = 3'd5; bus.op_a = 32'd50; bus.op_b = 32'd5; bus.rd_in = 5'd4; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.funct3 = 3'd5; bus.op_a = 32'd1; bus.op_b = 32'd1; bus.rd_in = 5'd9; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_mid_calc: got %b want 1", bus.busy); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_to_idle: busy %b want 0", bus.busy); end
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses want 0", pulses); end
    n_checks++; if (bus.result !== 32'd14) begin n_fail++; $display("FAIL flush_result_hold: got %h want 0000000e", bus.result); end
    n_checks++; if (bus.rd_out !== 5'd4) begin n_fail++; $display("FAIL busy_start_ignored: rd_out %0d want 4", bus.rd_out); end
    @(negedge clk);
    bus.funct3 = 3'd5; bus.op_a = 32'd9; bus.op_b = 32'd3; bus.rd_in = 5'd2;
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL start_with_flush: busy %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd4; bus.rd_in = 5'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL rst_mid_result: got %h want 0", bus.result); end
    n_checks++; if (bus.rd_out !== 5'd0) begin n_fail++; $display("FAIL rst_mid_rd_out: got %0d want 0", bus.rd_out); end
    n_checks++; if (bus.done !== 1'b0 || bus.wb_en !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_done: done %b wb_en %b want 0 0", bus.done, bus.wb_en);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'd0;
    bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0;
    repeat (2) @(posedge clk); #1;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_mul();
    test_mulh();
    test_div();
    test_overflow();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file and consumes its two read-port outputs (R1, R2) as operands.
- Produces a result plus destination register index and write enable toward the writeback path, which feeds the register file write port.
- One operation is in flight at a time, with a start/busy/done handshake to the pipeline control.

Parameters:
N, 32, operand/result width in bits
CW, 6, iteration counter width; must satisfy 2^CW > N

Ports:
clk     input   1     clock; all state updates on rising edge
rst     input   1     asynchronous reset, active-low (asserted at 0)
start   input   1     request; sampled only in IDLE
flush   input   1     abort the current operation (pipeline kill)
funct3  input   3     RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
op_a    input   N     rs1 value (from register file R1)
op_b    input   N     rs2 value (from register file R2)
rd_in   input   5     destination register index
busy    output  1     high in every state except IDLE
done    output  1     one-cycle pulse when result is valid
result  output  N     registered result; holds until next accepted start
rd_out  output  5     rd captured at start
wb_en   output  1     equals done AND (rd_out != 0)

Behaviour:
- Reset (rst=0, async): state IDLE; busy, done, wb_en = 0; result = 0; rd_out = 0; counter, accumulators = 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and flush=0 → capture funct3, rd_in, sign flags, operand magnitudes.
  - Normally → CALC with count=N.
  - Divide-class op with op_b=0 → FIX directly.
  - start is ignored in any other state.
- CALC:
  - One radix-2 step per cycle. MUL: shift-add over the 2N-bit product. DIV: restoring shift-subtract.
  - count decrements each cycle; at count=1 → FIX.
- FIX:
  - Apply sign correction, select output half/part, register result.
  - MUL takes the low N bits; MULH/MULHSU/MULHU take the high N bits.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: normal op, done is high N+2 cycles after the start-sampling edge (N CALC, 1 FIX, 1 DONE). Divide by zero: done is high 2 cycles after start.
- Signedness:
  - MULH: both operands signed. MULHSU: op_a signed, op_b unsigned. MULHU, DIVU, REMU: unsigned.
  - Signed quotient is negated when the operand signs differ. Remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones; remainder = op_a unmodified.
- Overflow (DIV/REM, op_a = 1 followed by N-1 zeros, op_b = all ones): quotient = op_a, remainder = 0. This falls out of the magnitude arithmetic and needs no trap.
- flush:
  - In CALC or FIX, the unit returns to IDLE on the next edge.
  - No done or wb_en is produced; result keeps its previous value.
  - flush in DONE: done still pulses that cycle, then IDLE.
  - flush and start together in IDLE: start is dropped.
- Reset mid-operation: immediate return to the reset state; no done.
- No back-pressure: done is a pulse and downstream must capture it.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: multiply ops (funct3 0-3) skip CALC and compute the 2N-bit product with a single-cycle multiplier in FIX. Multiply latency is then 2 cycles; divide is unchanged.
- Undefined: all ops use the iterative datapath with the latencies above.

Decomposition:
- Package muldiv_pkg: funct3 encodings (MUL..REMU), state enumeration, helper constants (op_is_div, op_is_signed_a, op_is_signed_b).
- One natural sub-module, muldiv_iter: the shared shift/add/subtract datapath plus counter. muldiv_unit keeps the FSM, operand capture, sign fix and output registers.

Test Plan:
- MUL, op_a=7, op_b=0xFFFFFFFD (-3) → result 0xFFFFFFEB; done exactly 34 cycles after start; wb_en=1 with rd_in=5.
- MULHU and MULH, op_a=op_b=0xFFFFFFFF → MULHU result 0xFFFFFFFE; MULH result 0x00000000.
- DIV and REM, op_a=0xFFFFFFF9 (-7), op_b=2 → DIV 0xFFFFFFFD (-3); REM 0xFFFFFFFF (-1). DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5, both with done 2 cycles after start.
- DIV and REM, op_a=0x80000000, op_b=0xFFFFFFFF → DIV 0x80000000, REM 0; rd_in=0 → done=1 but wb_en=0.
- Start DIVU 100/7 → quotient 14. Then start DIVU while busy at cycle 5, assert flush at cycle 10 → new start ignored, unit returns to IDLE, no done pulse, result still 14. Reset asserted mid-CALC → all outputs 0 immediately.
